// File: rtl/lsu_if.sv
// Core and memory side signals of the load/store unit.
// slave is the LSU view; master is the core plus memory view.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_wen, req_op,
    input  req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output mem_valid, mem_addr, mem_wen,
    output mem_wmask, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport master (
    output req_valid, req_wen, req_op,
    output req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  mem_valid, mem_addr, mem_wen,
    input  mem_wmask, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu.sv
// Single-outstanding load/store unit: aligns stores, formats loads,
// rejects illegal accesses and times out a stalled memory.
module lsu #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic rst,
  lsu_if.slave bus
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, RESP
  } state_t;

  state_t      state, state_n;
  logic [CW-1:0] cnt;
  logic        timeout;
  logic        illegal;
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  logic [31:0] ld_sh;
  logic [31:0] ld_fmt;
  logic        err_n;
  logic [31:0] rdata_n;
  logic [2:0]  op_q;
  logic [1:0]  off_q;

  logic        mem_valid_q, mem_wen_q;
  logic [3:0]  mem_wmask_q;
  logic [31:0] mem_wdata_q, mem_addr_q;
  logic        rsp_valid_q, rsp_err_q;
  logic [31:0] rsp_rdata_q;

  assign bus.req_ready = (state == IDLE);
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_wen   = mem_wen_q;
  assign bus.mem_wmask = mem_wmask_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  assign timeout = (cnt == CW'(MAX_WAIT - 1));

  always_comb begin
    illegal = 1'b0;
    if (bus.req_wen)
      illegal = !(bus.req_op inside {3'b000, 3'b001, 3'b010});
    else
      illegal = bus.req_op inside {3'b011, 3'b110, 3'b111};
    unique case (1'b1)
      bus.req_op[1:0] == 2'b01:
        if (bus.req_addr[0]) illegal = 1'b1;
      bus.req_op[1:0] == 2'b10:
        if (bus.req_addr[1:0] != 2'b00) illegal = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    st_mask = 4'b1111;
    st_data = bus.req_wdata;
    unique case (1'b1)
      bus.req_op[1:0] == 2'b00: begin
        st_mask = 4'b0001 << bus.req_addr[1:0];
        st_data = {4{bus.req_wdata[7:0]}};
      end
      bus.req_op[1:0] == 2'b01: begin
        st_mask = 4'b0011 << {bus.req_addr[1], 1'b0};
        st_data = {2{bus.req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign ld_sh = bus.mem_rdata >> {off_q, 3'b000};

  always_comb begin
    ld_fmt = ld_sh;
    unique case (1'b1)
      op_q == 3'b000: ld_fmt = {{24{ld_sh[7]}}, ld_sh[7:0]};
      op_q == 3'b001: ld_fmt = {{16{ld_sh[15]}}, ld_sh[15:0]};
      op_q == 3'b100: ld_fmt = {24'd0, ld_sh[7:0]};
      op_q == 3'b101: ld_fmt = {16'd0, ld_sh[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    err_n   = 1'b0;
    rdata_n = 32'd0;
    unique case (state)
      IDLE:
        if (bus.req_valid) begin
          state_n = illegal ? RESP : REQ;
          err_n   = illegal;
        end
      REQ:
        if (bus.mem_ready) begin
          state_n = mem_wen_q ? RESP : WAIT;
        end else if (timeout) begin
          state_n = RESP;
          err_n   = 1'b1;
        end
      WAIT:
        if (bus.mem_rvalid) begin
          state_n = RESP;
          rdata_n = ld_fmt;
        end else if (timeout) begin
          state_n = RESP;
          err_n   = 1'b1;
        end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      op_q        <= 3'd0;
      off_q       <= 2'd0;
      mem_valid_q <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_wmask_q <= 4'd0;
      mem_wdata_q <= 32'd0;
      mem_addr_q  <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      state       <= state_n;
      mem_valid_q <= (state_n == REQ);
      rsp_valid_q <= (state_n == RESP);
      if (state_n != state)
        cnt <= '0;
      else if (state == REQ || state == WAIT)
        cnt <= cnt + 1'b1;
      if (state_n == RESP) begin
        rsp_err_q   <= err_n;
        rsp_rdata_q <= rdata_n;
      end
      // Request fields stay latched so the bus is stable across stalls.
      if (state == IDLE && bus.req_valid) begin
        op_q        <= bus.req_op;
        off_q       <= bus.req_addr[1:0];
        mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
        mem_wen_q   <= bus.req_wen;
        mem_wmask_q <= bus.req_wen ? st_mask : 4'd0;
        mem_wdata_q <= bus.req_wen ? st_data : 32'd0;
      end
    end
  end
endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a response scoreboard.
// Expected responses carry the cycle they must appear in.
module tb_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          at;
  } exp_t;

  exp_t sb[$];

  lsu_if bus ();

  lsu #(.MAX_WAIT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_cycle", cyc, e.at);
        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
      end
    end
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] rd,
                      input logic err, input int lat);
    exp_t e;
    e.rdata = rd;
    e.err   = err;
    e.at    = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic drive_req(input logic wen,
                           input logic [2:0] op,
                           input logic [31:0] addr,
                           input logic [31:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_wen   = wen;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    nxt();
    bus.req_valid = 1'b0;
  endtask

  task automatic do_load(input string tag,
                         input logic [2:0] op,
                         input logic [31:0] addr,
                         input logic [31:0] rdata,
                         input logic [31:0] exp);
    push(exp, 1'b0, 3);
    drive_req(1'b0, op, addr, 32'd0);
    chk({tag, "_mvalid"}, {31'd0, bus.mem_valid}, 32'd1);
    chk({tag, "_maddr"}, bus.mem_addr, {addr[31:2], 2'b00});
    chk({tag, "_mwen"}, {31'd0, bus.mem_wen}, 32'd0);
    bus.mem_ready = 1'b1;
    nxt();
    bus.mem_ready  = 1'b0;
    chk({tag, "_mdrop"}, {31'd0, bus.mem_valid}, 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rdata;
    nxt();
    bus.mem_rvalid = 1'b0;
    nxt();
  endtask

  task automatic do_store(input string tag,
                          input logic [2:0] op,
                          input logic [31:0] addr,
                          input logic [31:0] wdata,
                          input logic [3:0] mask,
                          input logic [31:0] data,
                          input int stall);
    push(32'd0, 1'b0, 2 + stall);
    drive_req(1'b1, op, addr, wdata);
    chk({tag, "_mvalid"}, {31'd0, bus.mem_valid}, 32'd1);
    chk({tag, "_maddr"}, bus.mem_addr, {addr[31:2], 2'b00});
    chk({tag, "_mwen"}, {31'd0, bus.mem_wen}, 32'd1);
    chk({tag, "_mask"}, {28'd0, bus.mem_wmask}, {28'd0, mask});
    chk({tag, "_wdata"}, bus.mem_wdata, data);
    for (int i = 0; i < stall; i++) begin
      nxt();
      chk({tag, "_hold_v"}, {31'd0, bus.mem_valid}, 32'd1);
      chk({tag, "_hold_d"}, bus.mem_wdata, data);
    end
    bus.mem_ready = 1'b1;
    nxt();
    bus.mem_ready = 1'b0;
    chk({tag, "_mdrop"}, {31'd0, bus.mem_valid}, 32'd0);
    nxt();
  endtask

  task automatic do_illegal(input string tag,
                            input logic wen,
                            input logic [2:0] op,
                            input logic [31:0] addr);
    push(32'd0, 1'b1, 1);
    drive_req(wen, op, addr, 32'hFFFF_FFFF);
    chk({tag, "_nomem"}, {31'd0, bus.mem_valid}, 32'd0);
    nxt();
  endtask

  initial begin
    int  n;
    bit  done;
    bus.req_valid  = 1'b0;
    bus.req_wen    = 1'b0;
    bus.req_op     = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'd0;

    nxt();
    nxt();
    rst = 1'b0;
    nxt();
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_mvalid", {31'd0, bus.mem_valid}, 32'd0);
    chk("rst_mwen", {31'd0, bus.mem_wen}, 32'd0);
    chk("rst_mask", {28'd0, bus.mem_wmask}, 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    chk("rst_maddr", bus.mem_addr, 32'd0);
    chk("rst_rvalid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_err", {31'd0, bus.rsp_err}, 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);

    do_load("lb", 3'b000, 32'h8000_0003,
            32'h80FF_1234, 32'hFFFF_FF80);
    do_load("lhu", 3'b101, 32'h8000_0002,
            32'hABCD_0000, 32'h0000_ABCD);
    do_load("lh", 3'b001, 32'h0000_0000,
            32'h0000_8001, 32'hFFFF_8001);
    do_load("lbu", 3'b100, 32'h0000_0001,
            32'h0000_F100, 32'h0000_00F1);
    do_load("lw", 3'b010, 32'h0000_0004,
            32'hDEAD_BEEF, 32'hDEAD_BEEF);
    nxt();
    nxt();
    chk("hold_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
    chk("hold_err", {31'd0, bus.rsp_err}, 32'd0);

    do_store("sh", 3'b001, 32'h8000_0002, 32'h0000_BEEF,
             4'b1100, 32'hBEEF_BEEF, 0);
    chk("st_rdata0", bus.rsp_rdata, 32'd0);
    do_store("sb", 3'b000, 32'h0000_0001, 32'h1234_5678,
             4'b0010, 32'h7878_7878, 0);
    do_store("sw", 3'b010, 32'h0000_0008, 32'hCAFE_F00D,
             4'b1111, 32'hCAFE_F00D, 3);

    do_illegal("lw_mis", 1'b0, 3'b010, 32'h8000_0002);
    do_illegal("ld_op6", 1'b0, 3'b110, 32'h0000_0000);
    do_illegal("st_op4", 1'b1, 3'b100, 32'h0000_0000);
    do_illegal("sh_mis", 1'b1, 3'b001, 32'h0000_0001);
    nxt();
    chk("hold_err1", {31'd0, bus.rsp_err}, 32'd1);

    do_load("lw2", 3'b010, 32'h0000_0010,
            32'h1111_2222, 32'h1111_2222);

    push(32'd0, 1'b1, 17);
    drive_req(1'b0, 3'b010, 32'h0000_0020, 32'd0);
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (bus.mem_valid === 1'b1) n++;
      if (bus.rsp_valid === 1'b1) done = 1'b1;
      bus.req_valid  = (i == 4);
      bus.mem_rvalid = (i == 6);
      nxt();
    end
    bus.req_valid  = 1'b0;
    bus.mem_rvalid = 1'b0;
    chk("to_done", {31'd0, done}, 32'd1);
    chk("to_cycles", n, 32'd16);
    nxt();
    nxt();

    drive_req(1'b0, 3'b010, 32'h0000_0030, 32'd0);
    bus.mem_ready = 1'b1;
    nxt();
    bus.mem_ready = 1'b0;
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h5555_AAAA;
    nxt();
    bus.mem_rvalid = 1'b0;
    chk("ab_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("ab_rvalid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("ab_mvalid", {31'd0, bus.mem_valid}, 32'd0);
    chk("ab_rdata", bus.rsp_rdata, 32'd0);
    chk("ab_err", {31'd0, bus.rsp_err}, 32'd0);
    chk("ab_maddr", bus.mem_addr, 32'd0);
    chk("ab_mask", {28'd0, bus.mem_wmask}, 32'd0);
    repeat (4) nxt();

    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter MAX_WAIT, default 16: cycles allowed in REQ or WAIT before a timeout error.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  core load/store request.
REQ-005 req_ready  output  1  block can accept a request; high only in IDLE.
REQ-006 req_wen  input  1  1 = store, 0 = load (core MemWr).
REQ-007 req_op  input  3  RISC-V funct3 width code (core MemOP).
REQ-008 req_addr  input  32  byte address (ALU result).
REQ-009 req_wdata  input  32  store data (rs2).
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata  output  32  formatted load data for writeback.
REQ-012 rsp_err  output  1  misaligned, illegal op, or timeout; valid with rsp_valid.
REQ-013 mem_valid  output  1  memory request.
REQ-014 mem_ready  input  1  memory accepts the request.
REQ-015 mem_addr  output  32  word-aligned address: {addr[31:2],2'b00}.
REQ-016 mem_wen / mem_wmask / mem_wdata  output  1/4/32  write enable, byte strobes, aligned data.
REQ-017 mem_rvalid / mem_rdata  input  1/32  read data return.

Function
REQ-018 FSM states: IDLE, REQ, WAIT, RESP; state and all outputs except req_ready are registered.
REQ-019 IDLE, req_valid=1: latch wen/op/addr/wdata; go to RESP with err=1 if the request is illegal, else go to REQ.
REQ-020 Illegal request: load op in {011,110,111}; store op not in {000,001,010}; halfword access with addr[0]=1; word access with addr[1:0]!=0.
REQ-021 REQ: mem_valid=1, with mem_addr/mem_wen/mem_wmask/mem_wdata held stable until mem_ready=1.
REQ-022 REQ with mem_ready=1: a store goes to RESP (err=0); a load goes to WAIT; mem_valid falls the next cycle.
REQ-023 mem_rvalid is ignored in REQ and in IDLE.
REQ-024 WAIT with mem_rvalid=1: capture the formatted mem_rdata into rsp_rdata and go to RESP.
REQ-025 Store mask and data by op:
- sb: wmask=4'b0001<<addr[1:0]; wdata = byte replicated x4.
- sh: wmask=4'b0011<<{addr[1],1'b0}; wdata = halfword replicated x2.
- sw: wmask=4'b1111; wdata as given.
REQ-026 Load formatting: shift mem_rdata right by addr[1:0]*8, then:
- lb, lh: sign-extend.
- lbu, lhu: zero-extend.
- lw: pass through.
REQ-027 Timeout: a wait counter clears on entry to REQ and to WAIT and increments each cycle spent there. When it reaches MAX_WAIT the block goes to RESP with err=1, rdata=0, and drops mem_valid.
REQ-028 RESP: rsp_valid=1 for exactly one cycle, then IDLE; stores and errors return rsp_rdata=0.
REQ-029 rsp_rdata and rsp_err hold their values until the next RESP.
REQ-030 req_valid is ignored outside IDLE; no queuing.
REQ-031 Minimum latency:
- load: accept at cycle 0, mem_valid at cycle 1, rvalid at cycle 2, rsp_valid at cycle 3.
- store: rsp_valid at cycle 2.
- illegal request: rsp_valid at cycle 1.

Reset
REQ-032 rst=1 at an edge: state=IDLE, wait counter=0, and mem_valid, mem_wen, mem_wmask, mem_wdata, mem_addr, rsp_valid, rsp_err, rsp_rdata all 0; req_ready=1 from the first cycle after rst is released.
REQ-033 Reset mid-operation aborts the access with no rsp_valid; a late mem_rvalid after reset is ignored.

Verification
REQ-034 lb at addr 0x80000003, mem_rdata=0x80FF1234 -> mem_addr=0x80000000, rsp_rdata=0xFFFFFF80, err=0, rsp_valid at cycle 3.
REQ-035 sh at addr 0x80000002, wdata=0x0000BEEF -> mem_wmask=4'b1100, mem_wdata=0xBEEFBEEF, rsp_valid at cycle 2, rdata=0.
REQ-036 lw at addr 0x80000002 -> no mem_valid, rsp_valid at cycle 1 with err=1; lhu at 0x80000002 with rdata 0xABCD0000 -> rsp_rdata=0x0000ABCD.
REQ-037 Load with mem_ready held 0, MAX_WAIT=16 -> mem_valid for 16 cycles, then rsp_valid with err=1, rdata=0; a second req_valid pulsed during the wait produces no extra response.
REQ-038 rst asserted in WAIT, then mem_rvalid=1 in the cycle after release -> no rsp_valid, req_ready=1, all outputs 0.
